// File: rtl/btn_pkg.sv
// ============================================================================
// btn_pkg : shared state encoding and counter-width helpers for the buttons.
// Rev 1.0
// ============================================================================
`default_nettype none

package btn_pkg;

  localparam int BTN_STATE_W = 2;

  typedef enum logic [BTN_STATE_W-1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } btn_state_e;

  // Bits needed to hold values 0..n inclusive, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_channel.sv
// ============================================================================
// btn_channel : one debounce FSM with registered press strobe and level.
// Rev 1.0 -- auto-repeat counter present only with BTN_AUTOREPEAT_EN.
// ============================================================================
`default_nettype none

module btn_channel
  import btn_pkg::*;
#(
  parameter int DEB_TICKS     = 4,
  parameter int REPEAT_DELAY  = 100,
  parameter int REPEAT_PERIOD = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_sync,
  output logic o_pulse,
  output logic o_level
);

  localparam int c_cnt_w = cnt_width(DEB_TICKS);

  btn_state_e         r_state;
  btn_state_e         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [c_cnt_w-1:0] w_cnt_inc;
  logic               w_accept;
  logic               w_rep_pulse;
  logic               r_pulse;
  logic               r_level;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_sync) begin
          w_state_nxt = DEB_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      DEB_PRESS: begin
        // A bounce takes priority over a coincident tick.
        if (!i_sync) begin
          w_state_nxt = IDLE;
        end else if (i_tick) begin
          if (w_cnt_inc == c_cnt_w'(DEB_TICKS)) begin
            w_state_nxt = HELD;
            w_cnt_nxt   = '0;
            w_accept    = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      HELD: begin
        if (!i_sync) begin
          w_state_nxt = DEB_RELEASE;
          w_cnt_nxt   = '0;
        end
      end
      DEB_RELEASE: begin
        if (i_sync) begin
          w_state_nxt = HELD;
        end else if (i_tick) begin
          if (w_cnt_inc == c_cnt_w'(DEB_TICKS)) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int c_rep_w = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

  logic [c_rep_w-1:0] r_rep_cnt;
  logic               r_rep_armed;
  logic [c_rep_w-1:0] w_rep_inc;
  logic [c_rep_w-1:0] w_rep_target;
  logic               w_rep_live;

  assign w_rep_inc    = r_rep_cnt + 1'b1;
  assign w_rep_target = r_rep_armed ? c_rep_w'(REPEAT_PERIOD) : c_rep_w'(REPEAT_DELAY);
  assign w_rep_live   = (r_state == HELD) && i_sync;
  assign w_rep_pulse  = w_rep_live && i_tick && (w_rep_inc == w_rep_target);

  // First target is the initial delay; once it fires, the period takes over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
    end else if (!w_rep_live) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
    end else if (i_tick) begin
      if (w_rep_pulse) begin
        r_rep_cnt   <= '0;
        r_rep_armed <= 1'b1;
      end else begin
        r_rep_cnt <= w_rep_inc;
      end
    end
  end
`else
  assign w_rep_pulse = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_accept | w_rep_pulse;
      r_level <= (w_state_nxt == HELD) || (w_state_nxt == DEB_RELEASE);
    end
  end

  assign o_pulse = r_pulse;
  assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// button_conditioner : 2-flop sync, shared sample-tick prescaler, N channels.
// Rev 1.0 -- define BTN_AUTOREPEAT_EN to enable held-button auto-repeat.
// ============================================================================
`default_nettype none

module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN         = 5,
  parameter int TICK_DIV      = 157500,
  parameter int DEB_TICKS     = 4,
  parameter int REPEAT_DELAY  = 100,
  parameter int REPEAT_PERIOD = 20
) (
  input  logic             video_clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] btn_level
);

  localparam int c_pre_w = cnt_width(TICK_DIV - 1);

  logic [N_BTN-1:0]   r_sync1;
  logic [N_BTN-1:0]   r_sync2;
  logic [c_pre_w-1:0] r_pre;
  logic               w_tick;

  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_pre == c_pre_w'(TICK_DIV - 1));

  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_channel #(
      .DEB_TICKS    (DEB_TICKS),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .clk    (video_clk),
      .rst_n  (reset_n),
      .i_tick (w_tick),
      .i_sync (r_sync2[g]),
      .o_pulse(press_pulse[g]),
      .o_level(btn_level[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// tb_button_conditioner : vector table, corner sequences and random stimulus
// against a run-length reference model of the debouncer.
// ============================================================================
`default_nettype none

module tb_button_conditioner;

  localparam int N  = 5;
  localparam int TD = 4;
  localparam int DT = 3;
  localparam int RD = 5;
  localparam int RP = 2;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] btn_raw;
  logic [N-1:0] press_pulse;
  logic [N-1:0] btn_level;

  button_conditioner #(
    .N_BTN(N), .TICK_DIV(TD), .DEB_TICKS(DT), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .video_clk  (clk),
    .reset_n    (reset_n),
    .btn_raw    (btn_raw),
    .press_pulse(press_pulse),
    .btn_level  (btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: a button's accepted level flips once the raw level, seen two
  // cycles late, has disagreed with it for DT sample ticks (the first cycle of
  // disagreement only opens the window). Held time is measured in ticks.
  typedef struct {
    logic [N-1:0] s1, s2, lvl, pend, pulse;
    int           pc;
    int           tk[N];
    int           hd[N];
  } mstate_t;

  mstate_t m;

  function automatic mstate_t reset_m();
    mstate_t r;
    r.s1 = '0; r.s2 = '0; r.lvl = '0; r.pend = '0; r.pulse = '0; r.pc = 0;
    for (int i = 0; i < N; i++) begin
      r.tk[i] = 0;
      r.hd[i] = 0;
    end
    return r;
  endfunction

  function automatic mstate_t next_m(input mstate_t c, input logic [N-1:0] raw);
    mstate_t n;
    bit      t;
    n       = c;
    n.pulse = '0;
    t       = (c.pc == TD - 1);
    for (int i = 0; i < N; i++) begin
      if (c.s2[i] == c.lvl[i]) begin
        n.pend[i] = 1'b0;
        n.tk[i]   = 0;
        if (!c.lvl[i] || c.pend[i]) begin
          n.hd[i] = 0;
        end else if (t) begin
          n.hd[i] = c.hd[i] + 1;
`ifdef BTN_AUTOREPEAT_EN
          if (n.hd[i] >= RD && ((n.hd[i] - RD) % RP) == 0) n.pulse[i] = 1'b1;
`endif
        end
      end else begin
        n.hd[i] = 0;
        if (!c.pend[i]) begin
          n.pend[i] = 1'b1;
          n.tk[i]   = 0;
        end else if (t) begin
          n.tk[i] = c.tk[i] + 1;
          if (n.tk[i] == DT) begin
            n.lvl[i]   = c.s2[i];
            n.pend[i]  = 1'b0;
            n.tk[i]    = 0;
            n.pulse[i] = c.s2[i];
          end
        end
      end
    end
    n.s2 = c.s1;
    n.s1 = raw;
    n.pc = (c.pc + 1) % TD;
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= reset_m();
    else          m <= next_m(m, btn_raw);
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pulse", int'(press_pulse), int'(m.pulse));
      check("model_level", int'(btn_level), int'(m.lvl));
    end
  end

  int           cyc;
  int           pcnt[N];
  bit           seen;
  logic [N-1:0] first_vec;
  int           first_cyc;
  int           pq[$];

  task automatic clear_counts();
    cyc = 0; seen = 1'b0; first_vec = '0; first_cyc = 0; pq.delete();
    for (int i = 0; i < N; i++) pcnt[i] = 0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) if (press_pulse[i]) pcnt[i]++;
      if (press_pulse != '0) begin
        pq.push_back(cyc);
        if (!seen) begin
          seen      = 1'b1;
          first_vec = press_pulse;
          first_cyc = cyc;
        end
      end
    end
  endtask

  function automatic int total_pulses();
    int s = 0;
    for (int i = 0; i < N; i++) s += pcnt[i];
    return s;
  endfunction

  typedef struct {
    logic [N-1:0] raw;
    int           cycles;
    logic [N-1:0] exp_level;
    int           exp_pulses;
  } vec_t;

  vec_t tbl[10];
  int   exp_rep[5];

  initial begin
    tbl[0] = '{5'b00000,  8, 5'b00000, 0};
    tbl[1] = '{5'b00001, 16, 5'b00001, 1};
    tbl[2] = '{5'b00000, 16, 5'b00000, 0};
    tbl[3] = '{5'b00100,  7, 5'b00000, 0};
    tbl[4] = '{5'b00000, 16, 5'b00000, 0};
    tbl[5] = '{5'b11111, 16, 5'b11111, 5};
    tbl[6] = '{5'b00000, 16, 5'b00000, 0};
    tbl[7] = '{5'b01010, 16, 5'b01010, 2};
    tbl[8] = '{5'b01000, 16, 5'b01000, 0};
    tbl[9] = '{5'b00000, 16, 5'b00000, 0};
    exp_rep = '{20, 28, 36, 44, 52};

    reset_n = 1'b0;
    btn_raw = '0;
    clear_counts();
    chk_en = 1'b1;
    run(3);
    check("reset_level", int'(btn_level), 0);
    check("reset_pulse", int'(press_pulse), 0);
    reset_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      clear_counts();
      btn_raw = tbl[v].raw;
      run(tbl[v].cycles);
      check($sformatf("vec%0d_level", v), int'(btn_level), int'(tbl[v].exp_level));
      check($sformatf("vec%0d_pulses", v), total_pulses(), tbl[v].exp_pulses);
      if (tbl[v].exp_pulses > 1)
        check($sformatf("vec%0d_simultaneous", v), int'(first_vec), int'(tbl[v].raw));
    end

    // Bouncing input, then stable: one pulse only after a full debounce.
    clear_counts();
    for (int k = 0; k < 10; k++) begin
      btn_raw[1] = (k % 2 == 0);
      run(3);
    end
    check("bounce_no_pulse", pcnt[1], 0);
    clear_counts();
    btn_raw[1] = 1'b1;
    run(20);
    check("bounce_pulses", pcnt[1], 1);
    check("bounce_latency_ok", int'(first_cyc >= 12 && first_cyc <= 15), 1);
    btn_raw = '0;
    run(16);

    // Asynchronous reset while one channel is held and another debouncing.
    clear_counts();
    btn_raw = 5'b00001;
    run(16);
    check("pre_reset_level", int'(btn_level), 1);
    btn_raw = 5'b01001;
    run(6);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_level", int'(btn_level), 0);
    check("async_reset_pulse", int'(press_pulse), 0);
    run(2);
    reset_n = 1'b1;
    clear_counts();
    run(20);
    check("post_reset_pulse_ch0", pcnt[0], 1);
    check("post_reset_pulse_ch3", pcnt[3], 1);
    check("post_reset_level", int'(btn_level), 9);
    btn_raw = '0;
    run(16);

    // Long hold: pulse count and spacing depend on auto-repeat.
    clear_counts();
    btn_raw = 5'b10000;
    for (int k = 0; k < 40 && !seen; k++) run(1);
    check("hold_accepted", int'(seen), 1);
    run(56);
`ifdef BTN_AUTOREPEAT_EN
    check("hold_pulses", pcnt[4], 6);
    for (int j = 0; j < 5; j++)
      if (pq.size() > j + 1)
        check($sformatf("repeat_offset%0d", j), pq[j+1] - first_cyc, exp_rep[j]);
`else
    check("hold_pulses", pcnt[4], 1);
`endif
    btn_raw = '0;
    run(20);

    // Random levels with random hold times, compared cycle-by-cycle.
    for (int r = 0; r < 60; r++) begin
      btn_raw = N'($urandom);
      run(int'($urandom_range(1, 24)));
    end
    btn_raw = '0;
    run(20);
    check("final_level", int'(btn_level), 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
